key_input_unit: RTL



---
 rtl/key_input_unit_pkg.sv | 14 +
 rtl/key_input_unit_if.sv | 16 +
 rtl/key_input_unit_debounce.sv | 55 +++++
 rtl/key_input_unit.sv | 84 ++++++++
 4 files changed

// File: rtl/key_input_unit_pkg.sv
// Shared constants for the key/switch input peripheral: register word indices
// and the default debounce length.
package key_input_unit_pkg;

  localparam logic [1:0] KIU_LEVEL = 2'd0;
  localparam logic [1:0] KIU_FLAGS = 2'd1;
  localparam logic [1:0] KIU_SW    = 2'd2;
  localparam logic [1:0] KIU_MASK  = 2'd3;

  // 10 ms at the 1 MHz system clock
  localparam int KIU_DEBOUNCE_DEFAULT = 10000;
  localparam int KIU_CNT_W_DEFAULT    = 14;

endpackage

// File: rtl/key_input_unit_if.sv
// CPU-side bus of the key input unit: word select, strobes, data and interrupt.
interface key_input_unit_if;
  // Handshake: rd and we are single-cycle strobes qualified by addr. There is no
  // valid/ready backpressure: the peripheral is always ready, rdata is valid in
  // the same cycle, and side effects (read-clear, mask write) take effect at the
  // next rising clock edge.
  logic [1:0]  addr;
  logic        rd;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, rd, we, wdata, input rdata, irq);
  modport slave  (input addr, rd, we, wdata, output rdata, irq);
endinterface

// File: rtl/key_input_unit_debounce.sv
// One key: two-flop synchroniser, stability counter and accepted level, with a
// press pulse in the cycle before key_level rises.
module key_debounce
  import key_input_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KIU_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = KIU_CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic key_level,
  output logic press_event
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Synchroniser idles at 1 so a reset reads as "released".
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign key_s  = ~sync2;
  assign accept = (key_s != key_level) && (cnt == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      key_level <= 1'b0;
    end else if (key_s == key_level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      key_level <= key_s;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Aligned with the edge that raises key_level, so flags set on that same edge.
  assign press_event = accept & key_s;

endmodule

// File: rtl/key_input_unit.sv
// Memory-mapped key/switch input peripheral: debounced keys, sticky press flags
// cleared on read, switch synchroniser, and a maskable level interrupt.
module key_input_unit
  import key_input_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KIU_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = KIU_CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       key_n,
  input  logic [9:0]       sw,
  key_input_unit_if.slave  bus
);

  logic [3:0]  key_level;
  logic [3:0]  press_event;
  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;
  logic [3:0]  press_flags;
  logic [3:0]  press_flags_next;
  logic [3:0]  irq_mask;
  logic [3:0]  irq_mask_next;
  logic        clr;
  logic        irq_q;
  logic [31:0] rdata;
  logic        unused_wdata;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clock      (clock),
      .resetn     (resetn),
      .key_n      (key_n[k]),
      .key_level  (key_level[k]),
      .press_event(press_event[k])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // A press coinciding with a clearing read survives: set wins over clear.
  assign clr              = bus.rd && (bus.addr == KIU_FLAGS);
  assign press_flags_next = (press_flags & ~{4{clr}}) | press_event;
  assign irq_mask_next    = (bus.we && (bus.addr == KIU_MASK)) ? bus.wdata[3:0] : irq_mask;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      press_flags <= '0;
      irq_mask    <= '0;
      irq_q       <= 1'b0;
    end else begin
      press_flags <= press_flags_next;
      irq_mask    <= irq_mask_next;
      irq_q       <= |(press_flags_next & irq_mask_next);
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      KIU_LEVEL: rdata = {28'b0, key_level};
      KIU_FLAGS: rdata = {28'b0, press_flags};
      KIU_SW:    rdata = {22'b0, sw_sync};
      KIU_MASK:  rdata = {28'b0, irq_mask};
      default:   rdata = '0;
    endcase
  end

  assign bus.rdata    = rdata;
  assign bus.irq      = irq_q;
  assign unused_wdata = ^bus.wdata[31:4];

endmodule
